viterbi_ctrl: RTL
=================

Name: viterbi_ctrl

Overview:
- Frame-level sequencer for the K=3, rate-1/2, 4-state Viterbi decoder.
- Accepts 2-bit received symbols from the PISO via a valid/ready handshake.
- Gates the BMU/ACS update and survivor-memory writes, one trellis step per accepted symbol.
- After FRAME_LEN symbols, runs the traceback address sequence and reports frame completion.

Parameters:
- FRAME_LEN, 16: trellis steps (symbols) per frame, including tail bits; legal range 2..2**ADDR_W.
- ADDR_W, 4: survivor-memory address width; must satisfy 2**ADDR_W >= FRAME_LEN.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  frame start request; sampled only in IDLE.
- abort_i  in  1  cancels the current frame from any state.
- sym_valid_i  in  1  PISO symbol valid.
- sym_data_i  in  2  received symbol {bit1, bit0}.
- sym_ready_o  out  1  controller accepts a symbol this cycle.
- bmu_data_o  out  2  symbol forwarded to the BMU piso_data_i.
- pm_init_o  out  1  path-metric init pulse: S0=0, S1..S3=max.
- acs_en_o  out  1  ACS/path-metric register update enable.
- sm_wr_en_o  out  1  survivor-memory write enable.
- sm_wr_addr_o  out  ADDR_W  survivor-memory write address.
- tb_en_o  out  1  traceback step enable.
- tb_first_o  out  1  first traceback step; traceback starts from state S0.
- tb_addr_o  out  ADDR_W  survivor-memory read address.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset: state=IDLE; sym_cnt=0; tb_cnt=0. All outputs 0, including bmu_data_o and both address outputs.
- State sequence: IDLE -> INIT -> ACS -> TB -> DONE -> IDLE.
- IDLE:
  - sym_ready_o=0.
  - start_i=1 -> INIT. Otherwise hold.
- INIT (exactly 1 cycle):
  - pm_init_o=1; sym_cnt cleared to 0.
  - Next state ACS.
- ACS:
  - sym_ready_o=1 (combinational, state decode only).
  - Accept = sym_valid_i & sym_ready_o.
  - On accept, in the same cycle: acs_en_o=1, sm_wr_en_o=1, sm_wr_addr_o=sym_cnt, bmu_data_o=sym_data_i.
  - Without accept: acs_en_o=0, sm_wr_en_o=0, bmu_data_o=0.
  - sym_cnt increments by 1 on each accept.
  - Accept with sym_cnt==FRAME_LEN-1 -> TB, tb_cnt loaded with FRAME_LEN-1.
  - sym_valid_i low stalls indefinitely with no counter change.
- TB (exactly FRAME_LEN cycles):
  - tb_en_o=1; tb_addr_o=tb_cnt.
  - tb_cnt decrements by 1 per cycle: FRAME_LEN-1 down to 0.
  - tb_first_o=1 only in the first TB cycle (tb_cnt==FRAME_LEN-1).
  - sym_ready_o=0.
  - tb_cnt==0 -> DONE.
- DONE (exactly 1 cycle):
  - done_o=1.
  - Next state IDLE. A start_i asserted during DONE is ignored.
- abort_i:
  - Highest priority after rst_i, in any non-IDLE state.
  - Next state IDLE; counters cleared; done_o not asserted.
  - In an ACS cycle with abort_i=1, sym_ready_o still reads 1 but nothing is committed: acs_en_o=0, sm_wr_en_o=0.
- Simultaneous start_i and abort_i in IDLE: abort wins, stay in IDLE.
- rst_i mid-frame: same as the reset state above on the next edge.
- Counters never wrap in legal operation. sym_cnt saturates the state transition at FRAME_LEN-1.
- Cycle count from start_i edge to done_o, with no stalls: 1 (INIT) + FRAME_LEN (ACS) + FRAME_LEN (TB) + 1 = 2*FRAME_LEN+2 edges.

Optional Feature:
- Macro: VITERBI_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [15:0].
  - Counts ACS-state cycles with sym_valid_i=0.
  - Saturates at 16'hFFFF.
  - Cleared in INIT and on reset; holds its value in TB, DONE and IDLE.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Nominal frame, FRAME_LEN=16, sym_valid_i held 1, start_i pulse at cycle 0:
  - pm_init_o at cycle 1.
  - acs_en_o/sm_wr_en_o at cycles 2..17, with sm_wr_addr_o 0..15.
  - tb_en_o at cycles 18..33, with tb_addr_o 15..0; tb_first_o only at cycle 18.
  - done_o at cycle 34.
- Data forwarding: symbols 00,11,01,10 repeated over the frame -> bmu_data_o equals sym_data_i on every accept cycle and is 0 otherwise.
- Stalls: sym_valid_i toggled 1,0,0,1,... -> acs_en_o count equals accepts; sm_wr_addr_o strictly 0..15 with no skips or repeats; done_o at cycle 34 plus the number of stall cycles.
- Abort in ACS after 5 accepts:
  - Next cycle: busy_o=0, no done_o.
  - A new start_i yields sm_wr_addr_o restarting at 0.
- Reset mid-TB (rst_i high at tb_addr_o=7): next cycle all outputs 0, state IDLE. start_i while busy_o=1 is ignored.
- With VITERBI_CTRL_STALL_CNT_EN defined: 3 stall cycles in ACS -> stall_cnt_o=3 after done_o; cleared to 0 one cycle after the next INIT.

Source files
------------

// File: rtl/viterbi_ctrl.sv
// ----------------------------------------------------------------------------
// viterbi_ctrl
// Frame-level sequencer for a K=3, rate-1/2, 4-state Viterbi decoder.
//
// Flow per frame: IDLE -> INIT -> ACS -> TB -> DONE -> IDLE
//   INIT : one-cycle path-metric init pulse.
//   ACS  : one trellis step per accepted symbol (valid/ready handshake);
//          forwards the symbol to the BMU, enables the ACS update and
//          writes one survivor-memory column per step.
//   TB   : FRAME_LEN traceback steps, reading the survivor memory from the
//          last written address down to 0.
//   DONE : one-cycle completion pulse.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, abort_i        frame start (IDLE only) / frame cancel (any state)
//   sym_valid_i, sym_data_i incoming 2-bit symbols from the PISO
//   sym_ready_o             symbol accepted this cycle when valid is high
//   bmu_data_o              symbol forwarded to the BMU (0 when not accepting)
//   pm_init_o               path-metric initialisation pulse
//   acs_en_o                ACS / path-metric register update enable
//   sm_wr_en_o, sm_wr_addr_o survivor-memory write port control
//   tb_en_o, tb_first_o, tb_addr_o traceback step control / read address
//   busy_o, done_o          status
//   stall_cnt_o             (only with VITERBI_CTRL_STALL_CNT_EN) number of
//                           ACS cycles without a valid symbol, saturating
//
// Optional feature macro: VITERBI_CTRL_STALL_CNT_EN
// ----------------------------------------------------------------------------
module viterbi_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              sym_valid_i,
    input  logic [1:0]        sym_data_i,
    output logic              sym_ready_o,
    output logic [1:0]        bmu_data_o,
    output logic              pm_init_o,
    output logic              acs_en_o,
    output logic              sm_wr_en_o,
    output logic [ADDR_W-1:0] sm_wr_addr_o,
    output logic              tb_en_o,
    output logic              tb_first_o,
    output logic [ADDR_W-1:0] tb_addr_o,
    output logic              busy_o,
    output logic              done_o
`ifdef VITERBI_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ACS  = 3'd2,
        S_TB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [ADDR_W-1:0] tb_cnt_q, tb_cnt_d;
    logic              accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sym_cnt_q <= '0;
            tb_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            tb_cnt_q  <= tb_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        tb_cnt_d     = tb_cnt_q;
        accept       = 1'b0;
        sym_ready_o  = 1'b0;
        bmu_data_o   = 2'b00;
        pm_init_o    = 1'b0;
        acs_en_o     = 1'b0;
        sm_wr_en_o   = 1'b0;
        sm_wr_addr_o = '0;
        tb_en_o      = 1'b0;
        tb_first_o   = 1'b0;
        tb_addr_o    = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                busy_o    = 1'b1;
                pm_init_o = 1'b1;
                sym_cnt_d = '0;
                state_d   = S_ACS;
            end
            S_ACS: begin
                busy_o       = 1'b1;
                // ready is a pure state decode; abort only blocks the commit
                sym_ready_o  = 1'b1;
                sm_wr_addr_o = sym_cnt_q;
                accept       = sym_valid_i && !abort_i;
                if (accept) begin
                    acs_en_o   = 1'b1;
                    sm_wr_en_o = 1'b1;
                    bmu_data_o = sym_data_i;
                    if (sym_cnt_q == LAST_IDX) begin
                        // hold sym_cnt here so it cannot wrap when
                        // FRAME_LEN == 2**ADDR_W
                        tb_cnt_d = LAST_IDX;
                        state_d  = S_TB;
                    end else begin
                        sym_cnt_d = sym_cnt_q + ONE;
                    end
                end
            end
            S_TB: begin
                busy_o     = 1'b1;
                tb_en_o    = 1'b1;
                tb_addr_o  = tb_cnt_q;
                tb_first_o = (tb_cnt_q == LAST_IDX);
                if (tb_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tb_cnt_d = tb_cnt_q - ONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = !abort_i;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            sym_cnt_d = '0;
            tb_cnt_d  = '0;
        end
    end

`ifdef VITERBI_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_INIT) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_ACS) && !sym_valid_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
